// File: rtl/branch_resolver.sv
// branch_resolver: in-order queue of fetch-side branch predictions,
// checked against EX outcomes to drive redirects and predictor training.
module branch_resolver #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              push_valid_i,
   input  logic [ADDR_W-1:0] push_pc_i,
   input  logic              push_pred_taken_i,
   input  logic [ADDR_W-1:0] push_pred_target_i,
   output logic              full_o,
   input  logic              resolve_valid_i,
   input  logic              resolve_taken_i,
   input  logic [ADDR_W-1:0] resolve_target_i,
   output logic              jump_enable_o,
   output logic [ADDR_W-1:0] jump_pc_o,
   output logic              is_branch_o,
   output logic              branch_taken_o,
   output logic [ADDR_W-1:0] branch_pc_o,
   output logic [ADDR_W-1:0] branch_target_o,
   output logic [31:0]       branch_cnt_o,
   output logic [31:0]       mispredict_cnt_o,
   output logic              err_o
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     head_q, head_d;
   logic [PW-1:0]     tail_q, tail_d;
   logic              je_q, je_d;
   logic [ADDR_W-1:0] jpc_q, jpc_d;
   logic              isb_q, isb_d;
   logic              btk_q, btk_d;
   logic [ADDR_W-1:0] bpc_q, bpc_d;
   logic [ADDR_W-1:0] btg_q, btg_d;
   logic [31:0]       bcnt_q, bcnt_d;
   logic [31:0]       mcnt_q, mcnt_d;
   logic              err_q, err_d;

   logic [ADDR_W-1:0] pc_mem [DEPTH];
   logic              tk_mem [DEPTH];
   logic [ADDR_W-1:0] tg_mem [DEPTH];

   logic              empty, full, run;
   logic              pop, mispred, push_ok;
   logic [ADDR_W-1:0] h_pc, h_tg;
   logic              h_tk;
   logic [PW-1:0]     head_nx;

   // Queue status, head entry lookup and per-cycle pop/push decisions
   always_comb begin
      empty   = (head_q == tail_q);
      full    = (head_q[IW-1:0] == tail_q[IW-1:0]) &&
                (head_q[IW] != tail_q[IW]);
      run     = (state_q == RUN);
      h_pc    = pc_mem[head_q[IW-1:0]];
      h_tk    = tk_mem[head_q[IW-1:0]];
      h_tg    = tg_mem[head_q[IW-1:0]];
      head_nx = head_q + PW'(1);
      pop     = rdy && resolve_valid_i && run && !empty;
      mispred = pop && ((resolve_taken_i != h_tk) ||
                (resolve_taken_i && (resolve_target_i != h_tg)));
      push_ok = rdy && push_valid_i && run && !mispred &&
                (!full || pop);
   end

   // Next-state for pointers, FSM, feedback outputs and counters
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      je_d    = je_q;
      jpc_d   = jpc_q;
      isb_d   = isb_q;
      btk_d   = btk_q;
      bpc_d   = bpc_q;
      btg_d   = btg_q;
      bcnt_d  = bcnt_q;
      mcnt_d  = mcnt_q;
      err_d   = err_q;
      if (rdy) begin
         state_d = mispred ? FLUSH : RUN;
         je_d    = mispred;
         isb_d   = pop;
         if (pop) begin
            head_d = head_nx;
            btk_d  = resolve_taken_i;
            bpc_d  = h_pc;
            btg_d  = resolve_target_i;
            bcnt_d = bcnt_q + 32'd1;
         end
         if (mispred) begin
            tail_d = head_nx;
            jpc_d  = resolve_taken_i ? resolve_target_i
                                     : h_pc + ADDR_W'(4);
            mcnt_d = mcnt_q + 32'd1;
         end else if (push_ok) begin
            tail_d = tail_q + PW'(1);
         end
         if (resolve_valid_i && !pop)
            err_d = 1'b1;
      end
   end

   // Prediction storage; contents only matter between tail and head
   always_ff @(posedge clk) begin
      if (push_ok) begin
         pc_mem[tail_q[IW-1:0]] <= push_pc_i;
         tk_mem[tail_q[IW-1:0]] <= push_pred_taken_i;
         tg_mem[tail_q[IW-1:0]] <= push_pred_target_i;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= RUN;
         head_q  <= '0;
         tail_q  <= '0;
         je_q    <= 1'b0;
         jpc_q   <= '0;
         isb_q   <= 1'b0;
         btk_q   <= 1'b0;
         bpc_q   <= '0;
         btg_q   <= '0;
         bcnt_q  <= '0;
         mcnt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         je_q    <= je_d;
         jpc_q   <= jpc_d;
         isb_q   <= isb_d;
         btk_q   <= btk_d;
         bpc_q   <= bpc_d;
         btg_q   <= btg_d;
         bcnt_q  <= bcnt_d;
         mcnt_q  <= mcnt_d;
         err_q   <= err_d;
      end
   end

   assign full_o           = full;
   assign jump_enable_o    = je_q;
   assign jump_pc_o        = jpc_q;
   assign is_branch_o      = isb_q;
   assign branch_taken_o   = btk_q;
   assign branch_pc_o      = bpc_q;
   assign branch_target_o  = btg_q;
   assign branch_cnt_o     = bcnt_q;
   assign mispredict_cnt_o = mcnt_q;
   assign err_o            = err_q;

endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed vector table plus hand sequences
// for queue full/wrap, rdy stalls and reset during flush.
module tb_branch_resolver;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        push_valid_i;
   logic [31:0] push_pc_i;
   logic        push_pred_taken_i;
   logic [31:0] push_pred_target_i;
   logic        full_o;
   logic        resolve_valid_i;
   logic        resolve_taken_i;
   logic [31:0] resolve_target_i;
   logic        jump_enable_o;
   logic [31:0] jump_pc_o;
   logic        is_branch_o;
   logic        branch_taken_o;
   logic [31:0] branch_pc_o;
   logic [31:0] branch_target_o;
   logic [31:0] branch_cnt_o;
   logic [31:0] mispredict_cnt_o;
   logic        err_o;

   int errors = 0;
   int checks = 0;

   branch_resolver #(.DEPTH(8), .ADDR_W(32)) dut (
      .clk                (clk),
      .rst                (rst),
      .rdy                (rdy),
      .push_valid_i       (push_valid_i),
      .push_pc_i          (push_pc_i),
      .push_pred_taken_i  (push_pred_taken_i),
      .push_pred_target_i (push_pred_target_i),
      .full_o             (full_o),
      .resolve_valid_i    (resolve_valid_i),
      .resolve_taken_i    (resolve_taken_i),
      .resolve_target_i   (resolve_target_i),
      .jump_enable_o      (jump_enable_o),
      .jump_pc_o          (jump_pc_o),
      .is_branch_o        (is_branch_o),
      .branch_taken_o     (branch_taken_o),
      .branch_pc_o        (branch_pc_o),
      .branch_target_o    (branch_target_o),
      .branch_cnt_o       (branch_cnt_o),
      .mispredict_cnt_o   (mispredict_cnt_o),
      .err_o              (err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rst_n, rdy, pv, ppc, ptk, ptg, rv, rtk, rtg;
      logic [31:0] full, je, jpc, isb, btk, bpc, btg, bcnt, mcnt, err;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic apply(input logic r, input logic y,
                        input logic pv, input logic [31:0] ppc,
                        input logic ptk, input logic [31:0] ptg,
                        input logic rv, input logic rtk,
                        input logic [31:0] rtg);
      rst                = r;
      rdy                = y;
      push_valid_i       = pv;
      push_pc_i          = ppc;
      push_pred_taken_i  = ptk;
      push_pred_target_i = ptg;
      resolve_valid_i    = rv;
      resolve_taken_i    = rtk;
      resolve_target_i   = rtg;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string p, input vec_t v);
      chk({p, ".full"}, 32'(full_o), v.full);
      chk({p, ".je"},   32'(jump_enable_o), v.je);
      chk({p, ".jpc"},  jump_pc_o, v.jpc);
      chk({p, ".isb"},  32'(is_branch_o), v.isb);
      chk({p, ".btk"},  32'(branch_taken_o), v.btk);
      chk({p, ".bpc"},  branch_pc_o, v.bpc);
      chk({p, ".btg"},  branch_target_o, v.btg);
      chk({p, ".bcnt"}, branch_cnt_o, v.bcnt);
      chk({p, ".mcnt"}, mispredict_cnt_o, v.mcnt);
      chk({p, ".err"},  32'(err_o), v.err);
   endtask

   initial begin
      // rst rdy pv ppc ptk ptg rv rtk rtg |
      // full je jpc isb btk bpc btg bcnt mcnt err
      vecs[0]  = '{0,1,0,0,0,0,0,0,0,
                   0,0,0,0,0,0,0,0,0,0};
      vecs[1]  = '{1,1,1,'h100,1,'h200,0,0,0,
                   0,0,0,0,0,0,0,0,0,0};
      vecs[2]  = '{1,1,0,0,0,0,1,1,'h200,
                   0,0,0,1,1,'h100,'h200,1,0,0};
      vecs[3]  = '{1,1,0,0,0,0,0,0,0,
                   0,0,0,0,1,'h100,'h200,1,0,0};
      vecs[4]  = '{1,1,1,'h40,1,'h80,0,0,0,
                   0,0,0,0,1,'h100,'h200,1,0,0};
      vecs[5]  = '{1,1,0,0,0,0,1,0,'h44,
                   0,1,'h44,1,0,'h40,'h44,2,1,0};
      vecs[6]  = '{1,1,0,0,0,0,0,0,0,
                   0,0,'h44,0,0,'h40,'h44,2,1,0};
      vecs[7]  = '{1,1,1,'h10,1,'h30,0,0,0,
                   0,0,'h44,0,0,'h40,'h44,2,1,0};
      vecs[8]  = '{1,1,1,'h14,0,0,0,0,0,
                   0,0,'h44,0,0,'h40,'h44,2,1,0};
      vecs[9]  = '{1,1,1,'h18,0,0,0,0,0,
                   0,0,'h44,0,0,'h40,'h44,2,1,0};
      vecs[10] = '{1,1,1,'h1c,0,0,1,1,'h34,
                   0,1,'h34,1,1,'h10,'h34,3,2,0};
      vecs[11] = '{1,1,1,'h20,0,0,0,0,0,
                   0,0,'h34,0,1,'h10,'h34,3,2,0};
      vecs[12] = '{1,1,0,0,0,0,1,0,0,
                   0,0,'h34,0,1,'h10,'h34,3,2,1};
      vecs[13] = '{1,1,1,'hfffffffc,1,'h8,0,0,0,
                   0,0,'h34,0,1,'h10,'h34,3,2,1};
      vecs[14] = '{1,1,0,0,0,0,1,0,0,
                   0,1,0,1,0,'hfffffffc,0,4,3,1};
      vecs[15] = '{1,1,0,0,0,0,0,0,0,
                   0,0,0,0,0,'hfffffffc,0,4,3,1};
      vecs[16] = '{0,1,0,0,0,0,0,0,0,
                   0,0,0,0,0,0,0,0,0,0};

      for (int i = 0; i < 17; i++) begin
         apply(vecs[i].rst_n[0], vecs[i].rdy[0], vecs[i].pv[0],
               vecs[i].ppc, vecs[i].ptk[0], vecs[i].ptg,
               vecs[i].rv[0], vecs[i].rtk[0], vecs[i].rtg);
         chk_all($sformatf("v%0d", i), vecs[i]);
      end

      // Fill to DEPTH, then drop a push while full
      for (int i = 0; i < 8; i++)
         apply(1, 1, 1, 32'h1000 + 32'(4 * i), 0, 0, 0, 0, 0);
      chk("fill.full", 32'(full_o), 1);
      apply(1, 1, 1, 32'h9999, 0, 0, 0, 0, 0);
      chk("drop.full", 32'(full_o), 1);

      // Push+pop while full, draining 20 entries across wraps
      for (int k = 0; k < 20; k++) begin
         if (k < 12)
            apply(1, 1, 1, 32'h1000 + 32'(4 * (k + 8)), 0, 0,
                  1, 0, 32'hdead);
         else
            apply(1, 1, 0, 0, 0, 0, 1, 0, 32'hdead);
         chk($sformatf("wrap%0d.bpc", k), branch_pc_o,
             32'h1000 + 32'(4 * k));
         chk($sformatf("wrap%0d.isb", k), 32'(is_branch_o), 1);
         chk($sformatf("wrap%0d.je", k), 32'(jump_enable_o), 0);
         if (k < 12)
            chk($sformatf("wrap%0d.full", k), 32'(full_o), 1);
      end
      chk("wrap.bcnt", branch_cnt_o, 20);
      chk("wrap.mcnt", mispredict_cnt_o, 0);
      chk("wrap.full", 32'(full_o), 0);
      chk("wrap.err", 32'(err_o), 0);

      // Empty resolve: sticky error, counters unchanged
      apply(1, 1, 0, 0, 0, 0, 1, 1, 32'h4);
      chk("empty.err", 32'(err_o), 1);
      chk("empty.isb", 32'(is_branch_o), 0);
      chk("empty.bcnt", branch_cnt_o, 20);
      apply(1, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("sticky.err", 32'(err_o), 1);

      // rdy=0 ignores push and resolve and holds a pending pulse
      apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
      apply(1, 0, 1, 32'h500, 0, 0, 0, 0, 0);
      apply(1, 1, 1, 32'h600, 0, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 0, 1, 0, 32'h0);
      chk("rdy0.isb", 32'(is_branch_o), 0);
      chk("rdy0.bcnt", branch_cnt_o, 0);
      chk("rdy0.err", 32'(err_o), 0);
      apply(1, 1, 0, 0, 0, 0, 1, 0, 32'h0);
      chk("rdy1.bpc", branch_pc_o, 32'h600);
      chk("rdy1.bcnt", branch_cnt_o, 1);
      apply(1, 0, 1, 32'h700, 0, 0, 1, 0, 0);
      chk("hold.isb", 32'(is_branch_o), 1);
      chk("hold.bcnt", branch_cnt_o, 1);
      chk("hold.err", 32'(err_o), 0);
      apply(1, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("rel.isb", 32'(is_branch_o), 0);
      apply(1, 1, 0, 0, 0, 0, 1, 0, 0);
      chk("rdyq.err", 32'(err_o), 1);
      chk("rdyq.bcnt", branch_cnt_o, 1);

      // Reset during FLUSH with younger entries queued
      apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++)
         apply(1, 1, 1, 32'h2000 + 32'(4 * i), 1, 32'h3000, 0, 0, 0);
      apply(1, 1, 0, 0, 0, 0, 1, 0, 0);
      chk("flush.je", 32'(jump_enable_o), 1);
      chk("flush.jpc", jump_pc_o, 32'h2004);
      apply(0, 1, 1, 32'h2100, 0, 0, 1, 0, 0);
      chk_all("rstfl", '{0,0,0,0,0,0,0,0,0,
                         0,0,0,0,0,0,0,0,0,0});
      apply(1, 1, 0, 0, 0, 0, 1, 1, 32'h3000);
      chk("rstfl.err", 32'(err_o), 1);
      chk("rstfl.isb", 32'(is_branch_o), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
